// File: rtl/bilinear_simd_pipe.sv
// bilinear_simd_pipe
//   Three-stage bilinear interpolator producing LANES output pixels per beat.
//   S1 registers the accepted beat, S2 blends horizontally (top/bottom rows),
//   S3 blends vertically and drives o_pix. A stalled output (o_valid && !i_ready)
//   freezes every stage. i_flush empties the pipe on the next edge.
//
//   Optional feature: define BILINEAR_ROUND_EN to round half up in S3
//   instead of truncating.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   i_valid / o_ready     input handshake
//   i_mode                0 = SEQ (lane 0 only), 1 = SIMD (all lanes)
//   i_row0 / i_row1       LANES+1 pixels of top / bottom row
//   i_wx                  per-lane horizontal weight, i_wy shared vertical weight
//   i_flush               synchronous pipeline clear
//   o_valid / i_ready     output handshake
//   o_pix, o_lane_mask    interpolated pixels and their valid lanes
//   o_busy                any stage holds a beat
module bilinear_simd_pipe #(
  parameter int LANES  = 4,
  parameter int PIX_W  = 8,
  parameter int FRAC_W = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_valid,
  output logic                       o_ready,
  input  logic                       i_mode,
  input  logic [(LANES+1)*PIX_W-1:0] i_row0,
  input  logic [(LANES+1)*PIX_W-1:0] i_row1,
  input  logic [LANES*FRAC_W-1:0]    i_wx,
  input  logic [FRAC_W-1:0]          i_wy,
  input  logic                       i_flush,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [LANES*PIX_W-1:0]     o_pix,
  output logic [LANES-1:0]           o_lane_mask,
  output logic                       o_busy
);

  localparam int ROW_W = (LANES+1)*PIX_W;
  localparam int TOP_W = PIX_W + FRAC_W + 1;
  localparam int V_W   = TOP_W + FRAC_W + 1;
  localparam logic [FRAC_W:0] ONE = {1'b1, {FRAC_W{1'b0}}};

  logic stall;
  logic accept;

  logic                    s1_valid_reg, s2_valid_reg, s3_valid_reg;
  logic [ROW_W-1:0]        s1_row0_reg, s1_row1_reg;
  logic [LANES*FRAC_W-1:0] s1_wx_reg;
  logic [FRAC_W-1:0]       s1_wy_reg;
  logic                    s1_mode_reg;

  logic [LANES*TOP_W-1:0]  s2_top_reg, s2_bot_reg;
  logic [FRAC_W-1:0]       s2_wy_reg;
  logic                    s2_mode_reg;

  logic [LANES*PIX_W-1:0]  o_pix_reg;
  logic [LANES-1:0]        o_lane_mask_reg;

  logic [LANES*TOP_W-1:0]  top_next, bot_next;
  logic [LANES*PIX_W-1:0]  pix_next;
  logic [LANES-1:0]        mask_next;
  logic [FRAC_W:0]         wy_c;

  assign stall   = s3_valid_reg && !i_ready;
  assign o_ready = !i_flush && !stall;
  assign accept  = i_valid && o_ready;

  assign o_valid     = s3_valid_reg;
  assign o_pix       = o_pix_reg;
  assign o_lane_mask = o_lane_mask_reg;
  assign o_busy      = s1_valid_reg || s2_valid_reg || s3_valid_reg;

  assign wy_c      = ONE - {1'b0, s2_wy_reg};
  assign mask_next = s2_mode_reg ? {LANES{1'b1}} : LANES'(1);

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [PIX_W-1:0]  p1, p2, p3, p4;
    logic [FRAC_W-1:0] wx;
    logic [FRAC_W:0]   wx_c;
    logic [TOP_W-1:0]  top, bot;
    logic [V_W-1:0]    v_sum;
    logic              lane_on;

    assign p1   = s1_row0_reg[gi*PIX_W +: PIX_W];
    assign p2   = s1_row0_reg[(gi+1)*PIX_W +: PIX_W];
    assign p3   = s1_row1_reg[gi*PIX_W +: PIX_W];
    assign p4   = s1_row1_reg[(gi+1)*PIX_W +: PIX_W];
    assign wx   = s1_wx_reg[gi*FRAC_W +: FRAC_W];
    // Weight complement 2^F - wx needs one extra bit so wx = 0 gives exactly 1.0.
    assign wx_c = ONE - {1'b0, wx};

    assign top_next[gi*TOP_W +: TOP_W] = TOP_W'(p1) * TOP_W'(wx_c) + TOP_W'(p2) * TOP_W'(wx);
    assign bot_next[gi*TOP_W +: TOP_W] = TOP_W'(p3) * TOP_W'(wx_c) + TOP_W'(p4) * TOP_W'(wx);

    assign top = s2_top_reg[gi*TOP_W +: TOP_W];
    assign bot = s2_bot_reg[gi*TOP_W +: TOP_W];

`ifdef BILINEAR_ROUND_EN
    // Half-LSB bias; the sum stays below 2^(PIX_W+2*FRAC_W) so no overflow.
    assign v_sum = V_W'(top) * V_W'(wy_c) + V_W'(bot) * V_W'(s2_wy_reg)
                 + (V_W'(1) << (2*FRAC_W-1));
`else
    assign v_sum = V_W'(top) * V_W'(wy_c) + V_W'(bot) * V_W'(s2_wy_reg);
`endif

    // SEQ beats only carry lane 0; the others are forced to zero.
    assign lane_on = s2_mode_reg || (gi == 0);
    assign pix_next[gi*PIX_W +: PIX_W] = lane_on ? PIX_W'(v_sum >> (2*FRAC_W)) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg    <= 1'b0;
      s2_valid_reg    <= 1'b0;
      s3_valid_reg    <= 1'b0;
      s1_row0_reg     <= '0;
      s1_row1_reg     <= '0;
      s1_wx_reg       <= '0;
      s1_wy_reg       <= '0;
      s1_mode_reg     <= 1'b0;
      s2_top_reg      <= '0;
      s2_bot_reg      <= '0;
      s2_wy_reg       <= '0;
      s2_mode_reg     <= 1'b0;
      o_pix_reg       <= '0;
      o_lane_mask_reg <= '0;
    end else if (i_flush) begin
      // Flush wins over stall and over a same-cycle input beat.
      s1_valid_reg    <= 1'b0;
      s2_valid_reg    <= 1'b0;
      s3_valid_reg    <= 1'b0;
      o_pix_reg       <= '0;
      o_lane_mask_reg <= '0;
    end else if (!stall) begin
      s1_valid_reg    <= accept;
      s2_valid_reg    <= s1_valid_reg;
      s3_valid_reg    <= s2_valid_reg;
      s1_row0_reg     <= i_row0;
      s1_row1_reg     <= i_row1;
      s1_wx_reg       <= i_wx;
      s1_wy_reg       <= i_wy;
      s1_mode_reg     <= i_mode;
      s2_top_reg      <= top_next;
      s2_bot_reg      <= bot_next;
      s2_wy_reg       <= s1_wy_reg;
      s2_mode_reg     <= s1_mode_reg;
      o_pix_reg       <= s2_valid_reg ? pix_next  : '0;
      o_lane_mask_reg <= s2_valid_reg ? mask_next : '0;
    end
  end

endmodule

// File: doc/bilinear_simd_pipe.md
BILINEAR_SIMD_PIPE -- requirements
Module: bilinear_simd_pipe

Interface
REQ-001 SHALL have parameter LANES, default 4, number of output pixels per beat (range 1..16).
REQ-002 SHALL have parameter PIX_W, default 8, pixel width in bits.
REQ-003 SHALL have parameter FRAC_W, default 8, fractional weight width; a weight w means w/2^FRAC_W.
REQ-004 SHALL have port clk  input  1  single clock; all state is rising-edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port i_valid  input  1  input beat offered.
REQ-007 SHALL have port o_ready  output  1  input beat accepted when i_valid && o_ready.
REQ-008 SHALL have port i_mode  input  1  0 = SEQ (lane 0 only), 1 = SIMD (all lanes).
REQ-009 SHALL have port i_row0  input  (LANES+1)*PIX_W  top-row pixels; byte k at bits [k*PIX_W +: PIX_W].
REQ-010 SHALL have port i_row1  input  (LANES+1)*PIX_W  bottom-row pixels, same packing.
REQ-011 SHALL have port i_wx  input  LANES*FRAC_W  per-lane horizontal weight.
REQ-012 SHALL have port i_wy  input  FRAC_W  vertical weight, shared by all lanes.
REQ-013 SHALL have port i_flush  input  1  synchronous pipeline clear.
REQ-014 SHALL have port o_valid  output  1  output beat present.
REQ-015 SHALL have port i_ready  input  1  output beat consumed when o_valid && i_ready.
REQ-016 SHALL have port o_pix  output  LANES*PIX_W  interpolated pixels, lane k at [k*PIX_W +: PIX_W].
REQ-017 SHALL have port o_lane_mask  output  LANES  valid lanes of o_pix.
REQ-018 SHALL have port o_busy  output  1  any pipeline stage holds a beat.

Function
REQ-019 Lane k SHALL use p1=row0[k], p2=row0[k+1], p3=row1[k], p4=row1[k+1], wx=i_wx lane k.
REQ-020 Stage S1 SHALL register accepted inputs, mode and weights.
REQ-021 Stage S2 SHALL compute top=p1*(2^F-wx)+p2*wx and bot=p3*(2^F-wx)+p4*wx at full width PIX_W+FRAC_W+1, no truncation.
REQ-022 Stage S3 SHALL compute v=top*(2^F-wy)+bot*wy at full width and register result=v>>(2*FRAC_W) into o_pix.
REQ-023 Latency SHALL be exactly 3 cycles from acceptance edge to o_valid high, absent stalls; throughput one beat per cycle.
REQ-024 Global stall: when o_valid && !i_ready, all stages SHALL hold; o_ready SHALL be low.
REQ-025 o_ready SHALL equal !i_flush && !(o_valid && !i_ready).
REQ-026 o_pix, o_lane_mask SHALL remain stable while o_valid && !i_ready.
REQ-027 SEQ beat: o_lane_mask SHALL be 1 (lane 0 only), other lanes of o_pix SHALL be 0; SIMD beat: mask all ones.
REQ-028 Mode SHALL be carried per beat; mixed-mode beats in flight SHALL not interfere.
REQ-029 i_flush SHALL clear all stage valid bits next edge, overriding stall and same-cycle input; o_pix, o_lane_mask cleared to 0.
REQ-030 o_busy SHALL be OR of S1, S2, S3 valid bits.
REQ-031 Weight 0 SHALL select p1/p3 (resp. top) exactly; no weight reaches 1.0.

Reset
REQ-032 rst_n low SHALL asynchronously clear all valid bits, o_valid=0, o_pix=0, o_lane_mask=0, o_busy=0; o_ready=1 after release.
REQ-033 Reset mid-operation SHALL discard all in-flight beats; none emerge after release.

Configuration
REQ-034 With macro BILINEAR_ROUND_EN defined, S3 SHALL output (v+2^(2*FRAC_W-1))>>(2*FRAC_W) (round half up); result cannot exceed 2^PIX_W-1.
REQ-035 Without BILINEAR_ROUND_EN, S3 SHALL truncate (v>>(2*FRAC_W)).

Verification (LANES=4, PIX_W=8, FRAC_W=8)
REQ-036 All row bytes 100, any weights, SIMD -> o_pix all lanes 100, mask 4'b1111, o_valid 3 cycles after accept.
REQ-037 row0 byte0=0, byte1=200, wx lane0=128, wy=0, SEQ -> o_pix lane0=100, lanes1-3=0, mask 4'b0001.
REQ-038 row0 byte0=0, byte1=1, wx=128, wy=0 -> lane0=0 without BILINEAR_ROUND_EN, 1 with it.
REQ-039 Stream 6 beats, hold i_ready low 4 cycles at beat 2 -> o_ready low during stall, o_pix stable, all 6 beats emerge in order, none lost/duplicated.
REQ-040 i_flush with 3 beats in flight and i_valid high same cycle -> o_valid=0, o_busy=0 next cycle, no beat emerges; rst_n pulse mid-stream likewise empties pipe.
